servo_pwm_gen: RTL and testbench

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

---
 rtl/servo_pwm_gen.sv | 118 +++++++++++
 tb/tb_servo_pwm_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-length frames whose high time equals servo_position.
// Position commands are buffered and take effect only on the frame wrap edge.
module servo_pwm_gen #(
    parameter int unsigned PERIOD  = 2_000_000,
    parameter int unsigned PW_MIN  = 100_000,
    parameter int unsigned PW_MAX  = 200_000,
    parameter int unsigned PW_INIT = 150_000,
    parameter int unsigned STEP    = 1_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_inc,
    input  logic        cmd_dec,
    input  logic        cmd_set,
    input  logic [31:0] set_value,
    output logic        SERVO,
    output logic [31:0] servo_position,
    output logic        frame_start,
    output logic        pending,
    output logic        limit_min,
    output logic        limit_max
);

    // state    | meaning
    // ST_WAIT  | reset just released, first frame begins on the next edge
    // ST_RUN   | frames running, cnt walks 0..PERIOD-1
    typedef enum logic {ST_WAIT, ST_RUN} state_t;
    typedef enum logic [1:0] {CMD_INC, CMD_DEC, CMD_SET} cmd_t;

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [32:0]   STEP33   = 33'(STEP);
    localparam logic [32:0]   MIN33    = 33'(PW_MIN);
    localparam logic [32:0]   MAX33    = 33'(PW_MAX);

    state_t          state;
    logic [CW-1:0]   cnt;
    cmd_t            pend_type;
    logic [31:0]     pend_target;

    logic            new_cmd;
    cmd_t            new_type;
    logic            wrap;
    cmd_t            eff_type;
    logic [31:0]     eff_target;
    logic [32:0]     base;
    logic [32:0]     raw;
    logic [31:0]     clamped;
    logic [31:0]     pos_next;
    logic [CW-1:0]   cnt_next;

    always_comb begin
        new_cmd  = cmd_set | (cmd_inc ^ cmd_dec);
        new_type = CMD_DEC;
        if (cmd_set)
            new_type = CMD_SET;
        else if (cmd_inc)
            new_type = CMD_INC;

        wrap = (state == ST_RUN) && (cnt == CNT_LAST);

        // A command arriving in the last cycle of a frame wins over the buffered one.
        eff_type   = new_cmd ? new_type : pend_type;
        eff_target = new_cmd ? set_value : pend_target;

        base = {1'b0, servo_position};
        case (eff_type)
            CMD_INC: raw = base + STEP33;
            CMD_DEC: raw = (base >= STEP33) ? base - STEP33 : 33'd0;
            CMD_SET: raw = {1'b0, eff_target};
            default: raw = base;
        endcase

        if (raw < MIN33)
            clamped = 32'(PW_MIN);
        else if (raw > MAX33)
            clamped = 32'(PW_MAX);
        else
            clamped = raw[31:0];

        pos_next = (wrap && (new_cmd || pending)) ? clamped : servo_position;

        cnt_next = '0;
        if ((state == ST_RUN) && !wrap)
            cnt_next = cnt + CW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= ST_WAIT;
            cnt            <= '0;
            servo_position <= 32'(PW_INIT);
            SERVO          <= 1'b0;
            frame_start    <= 1'b0;
            pending        <= 1'b0;
            pend_type      <= CMD_INC;
            pend_target    <= '0;
        end else begin
            state          <= ST_RUN;
            cnt            <= cnt_next;
            servo_position <= pos_next;
            frame_start    <= (cnt_next == '0);
            // Compare against the next count and width so SERVO lines up with cnt.
            SERVO          <= (32'(cnt_next) < pos_next);
            if (wrap) begin
                pending <= 1'b0;
            end else if (new_cmd) begin
                pending     <= 1'b1;
                pend_type   <= new_type;
                pend_target <= set_value;
            end
        end
    end

    assign limit_min = (servo_position == 32'(PW_MIN));
    assign limit_max = (servo_position == 32'(PW_MAX));

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: a frame-level reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_servo_pwm_gen;

    localparam int unsigned PERIOD  = 100;
    localparam int unsigned PW_MIN  = 10;
    localparam int unsigned PW_MAX  = 20;
    localparam int unsigned PW_INIT = 15;
    localparam int unsigned STEP    = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_inc = 1'b0;
    logic        cmd_dec = 1'b0;
    logic        cmd_set = 1'b0;
    logic [31:0] set_value = '0;
    logic        SERVO;
    logic [31:0] servo_position;
    logic        frame_start;
    logic        pending;
    logic        limit_min;
    logic        limit_max;

    servo_pwm_gen #(
        .PERIOD(PERIOD), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX),
        .PW_INIT(PW_INIT), .STEP(STEP)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_inc(cmd_inc), .cmd_dec(cmd_dec), .cmd_set(cmd_set), .set_value(set_value),
        .SERVO(SERVO), .servo_position(servo_position), .frame_start(frame_start),
        .pending(pending), .limit_min(limit_min), .limit_max(limit_max)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        servo;
        logic        fs;
        logic        pend;
        logic [31:0] pos;
        logic        lmin;
        logic        lmax;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: frame offset, current width and one buffered command.
    bit     m_started;
    int     m_off;
    longint m_pos;
    bit     m_pend;
    int     m_ptype;     // 0 inc, 1 dec, 2 set
    longint m_pval;

    function automatic longint clamp(input longint v);
        if (v < PW_MIN) return PW_MIN;
        if (v > PW_MAX) return PW_MAX;
        return v;
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_off     = 0;
        m_pos     = PW_INIT;
        m_pend    = 0;
        m_ptype   = 0;
        m_pval    = 0;
    endtask

    // Advance the model by one clock edge using the inputs held before that edge.
    task automatic model_edge();
        bit     nv;
        int     ntype;
        int     t;
        longint v;
        nv    = cmd_set || (cmd_inc != cmd_dec);
        ntype = cmd_set ? 2 : (cmd_inc ? 0 : 1);
        if (m_started && m_off == int'(PERIOD) - 1) begin
            if (nv || m_pend) begin
                t = nv ? ntype : m_ptype;
                v = nv ? longint'(set_value) : m_pval;
                case (t)
                    0:       m_pos = clamp(m_pos + STEP);
                    1:       m_pos = clamp(m_pos - STEP);
                    default: m_pos = clamp(v);
                endcase
            end
            m_pend = 0;
            m_off  = 0;
        end else begin
            if (nv) begin
                m_pend  = 1;
                m_ptype = ntype;
                m_pval  = longint'(set_value);
            end
            m_off     = m_started ? m_off + 1 : 0;
            m_started = 1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.servo = m_started && (m_off < m_pos);
        e.fs    = m_started && (m_off == 0);
        e.pend  = m_pend;
        e.pos   = 32'(m_pos);
        e.lmin  = (m_pos == PW_MIN);
        e.lmax  = (m_pos == PW_MAX);
        exp_q.push_back(e);
    endtask

    // One cycle: edge, model update, optional async reset, expectation, inputs idle.
    task automatic adv(input bit r);
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
        RST = r;
        if (r) model_reset();
        push_exp();
        cmd_inc = 1'b0;
        cmd_dec = 1'b0;
        cmd_set = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) adv(0);
    endtask

    task automatic go_to(input int c);
        int n;
        n = 0;
        do begin
            adv(0);
            n++;
        end while (!(m_started && m_off == c) && n < 3 * int'(PERIOD));
        if (!(m_started && m_off == c)) begin
            miscompares++;
            $display("FAIL go_to: offset %0d never reached, model at %0d", c, m_off);
        end
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{SERVO, frame_start, pending, servo_position, limit_min, limit_max};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle_outputs t=%0t: got servo=%b fs=%b pend=%b pos=%0d lmin=%b lmax=%b, want servo=%b fs=%b pend=%b pos=%0d lmin=%b lmax=%b",
                             $time, a.servo, a.fs, a.pend, a.pos, a.lmin, a.lmax,
                             e.servo, e.fs, e.pend, e.pos, e.lmin, e.lmax);
                end
            end
        end
    end

    initial begin : stim
        int r;
        model_reset();
        adv(1);
        adv(1);
        adv(0);                       // release reset; next edge starts frame 0

        idle(250);                    // free-running frames at PW_INIT

        go_to(40); cmd_inc = 1'b1;    // width 15 -> 17
        idle(150);

        go_to(30); cmd_set = 1'b1; set_value = 32'd50;   // clamp to PW_MAX
        idle(100);
        go_to(30); cmd_set = 1'b1; set_value = 32'd3;    // clamp to PW_MIN
        idle(100);

        go_to(20); cmd_inc = 1'b1; cmd_dec = 1'b1;       // ignored
        idle(100);
        go_to(10); cmd_inc = 1'b1;
        go_to(60); cmd_dec = 1'b1;                       // last wins
        idle(100);

        go_to(99); cmd_inc = 1'b1;                       // applied on the very next edge
        idle(50);
        go_to(40); cmd_set = 1'b1; set_value = 32'd19;
        go_to(50);
        adv(1);                                          // mid-frame reset drops pending
        adv(1);
        adv(0);
        idle(120);

        go_to(PERIOD - 1); cmd_dec = 1'b1; cmd_set = 1'b1; set_value = 32'hFFFF_FFFF;
        idle(20);
        go_to(5); cmd_dec = 1'b1;
        go_to(PERIOD - 1); cmd_set = 1'b1; set_value = 32'd0;
        idle(120);

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       begin cmd_inc = 1'b1; end
            else if (r < 6)  begin cmd_dec = 1'b1; end
            else if (r < 8)  begin cmd_inc = 1'b1; cmd_dec = 1'b1; end
            else if (r < 10) begin
                cmd_set = 1'b1;
                set_value = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 30));
                if ($urandom_range(0, 1) == 1) cmd_inc = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                adv(1);
                adv(0);
            end else begin
                adv(0);
            end
        end

        idle(2);
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
